text_overlay: RTL and testbench
===============================

TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 Parameter BASE, default 0: first port_id of the 6-register block at BASE..BASE+5.
REQ-002 Parameter COLS, default 16: text columns, power of 2, 8..128.
REQ-003 Parameter ROWS, default 64: text rows, power of 2, 1..64; COLS*ROWS SHALL be at most 2048.
REQ-004 Parameter X0, default 112: window left edge in 8-pixel cells; Y0, default 0: window top edge in 16-line cells.
REQ-005 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 port_id  in  8  host register select.
REQ-008 out_port  in  8  host write data.
REQ-009 write_strobe  in  1  one-cycle write qualifier, sampled on clk and never used as a clock.
REQ-010 hdata  in  12  current pixel column.
REQ-011 vdata  in  12  current pixel line.
REQ-012 area  out  1  pixel lies inside the text window, delayed to align with out.
REQ-013 out  out  1  text foreground pixel.

Function
REQ-014 Writes SHALL occur only when write_strobe=1 and port_id is in BASE..BASE+5; all other port_id values SHALL be ignored.
REQ-015 BASE+0: store out_port at buf[addr], then addr <= (addr+1) mod (COLS*ROWS), wrapping from last cell to 0.
REQ-016 BASE+1: addr[7:0] <= out_port; BASE+2: addr[AW-1:8] <= out_port low bits, where AW = log2(COLS*ROWS); bits above AW-1 SHALL be dropped.
REQ-017 BASE+3: addr <= (out_port mod ROWS)*COLS, i.e. the start of that row.
REQ-018 BASE+4: scroll <= out_port mod ROWS.
REQ-019 BASE+5: ctrl <= out_port[1:0]; bit0 = enable, bit1 = invert.
REQ-020 Window: hdata in [X0*8, (X0+COLS)*8) and vdata in [Y0*16, (Y0+ROWS)*16).
REQ-021 Cell column c = hdata/8 - X0. Display row r = vdata/16 - Y0. Buffer row = (r+scroll) mod ROWS.
REQ-022 Read latency: buffer read 1 cycle, glyph lookup 1 cycle; area and out SHALL both lag hdata/vdata by exactly 2 cycles.
REQ-023 Glyph bit select (hdata[2:0]) and line select (vdata[3:0]) SHALL be delayed to stay aligned through the pipeline.
REQ-024 out = area & enable & (glyph_bit XOR invert). With enable=0, area SHALL still be driven and out SHALL be 0.
REQ-025 A write and a display read of the same cell in the same cycle: the display SHALL return the new data (write-first).
REQ-026 Only one register write can occur per cycle, so simultaneous register writes do not arise.

Reset
REQ-027 On rst=1 at a clk edge, the following SHALL be set and held while rst is high:
- addr=0, scroll=0, ctrl=2'b01;
- the pipeline valid bits SHALL be cleared;
- area=0, out=0;
- the blink counter SHALL be cleared.
REQ-028 Buffer contents SHALL NOT be cleared by reset.
REQ-029 A host write with rst=1 in the same cycle SHALL be discarded.
REQ-030 rst asserted mid-line: area and out SHALL be 0 on the next edge, and correct output SHALL resume 2 cycles after release.

Configuration
REQ-031 Macro TEXT_OVERLAY_CURSOR_EN, when defined, SHALL enable the blinking cursor at cell addr.
- A frame counter SHALL increment on each cycle with hdata=0 and vdata=0.
- Blink phase = counter bit 4, giving 16 frames on and 16 frames off.
- When the phase is 1, glyph lines 14 and 15 of the cursor cell SHALL be forced to 1 before invert is applied.
REQ-032 Without TEXT_OVERLAY_CURSOR_EN, there SHALL be no cursor logic and no frame counter; out follows REQ-024 exactly.

Structure
REQ-033 Package text_overlay_pkg SHALL hold:
- register offset constants REG_DATA=0, REG_ADDRL=1, REG_ADDRH=2, REG_ROW=3, REG_SCROLL=4, REG_CTRL=5;
- the ctrl bit positions;
- the pipeline latency constant, 2.
REQ-034 One sub-module, text_overlay_regs, SHALL contain:
- port decode;
- the addr, scroll and ctrl registers;
- the buffer write enable.
REQ-035 Buffer and glyph ROM SHALL be inferred or instantiated in text_overlay.

Verification
REQ-036 Defaults. Reset, write 0x41 to BASE+0 three times, scan row 0 -> buf[0..2]=0x41, addr=3, and 'A' pixels appear on out 2 cycles after matching hdata.
REQ-037 Address setters.
- Write BASE+3=5 -> addr=80 (COLS=16).
- Write BASE+1=0xFF, BASE+2=0x07 -> addr=1023.
- Then one BASE+0 write -> addr wraps to 0.
REQ-038 Scroll. Fill row 1 with 0x58, write BASE+4=1 -> display row 0 shows 'X'; write BASE+4=0 -> blank (code 0x00).
REQ-039 Ctrl.
- BASE+5=0x03 -> out inverted inside the window and 0 outside it.
- BASE+5=0x00 -> out=0 throughout, area unchanged.
REQ-040 Boundary and latency.
- area=0 at hdata=X0*8-1 and area=1 at hdata=X0*8, both observed 2 cycles later.
- Write-first collision: the same cell shows the new code.
- rst pulsed mid-line -> area=0 on the next cycle.
REQ-041 Cursor (with TEXT_OVERLAY_CURSOR_EN):
- after 16 frame starts, lines 14-15 of cell addr read 1;
- after 32 frame starts, the glyph is restored.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared constants for the text overlay: host register map, control bit
// positions and the display pipeline depth.
package text_overlay_pkg;

    // Register offsets relative to the block's BASE port id.
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_ADDRL  = 3'd1;
    localparam logic [2:0] REG_ADDRH  = 3'd2;
    localparam logic [2:0] REG_ROW    = 3'd3;
    localparam logic [2:0] REG_SCROLL = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;

    // Number of registers in the block.
    localparam logic [8:0] REG_COUNT  = 9'd6;

    // Control register bit positions and reset value (enabled, not inverted).
    localparam int         CTRL_EN_BIT  = 0;
    localparam int         CTRL_INV_BIT = 1;
    localparam logic [1:0] CTRL_RESET   = 2'b01;

    // Cycles from hdata/vdata to area/out: buffer read plus glyph lookup.
    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/text_overlay_regs.sv
// Host-side register block of the text overlay: decodes the six-port
// window at BASE, holds the cursor/write address, scroll and control
// registers, and produces the character buffer write enable.
module text_overlay_regs #(
    parameter int BASE = 0,
    parameter int COLS = 16,
    parameter int ROWS = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       port_id_i,
    input  logic [7:0]                       out_port_i,
    input  logic                             write_strobe_i,
    output logic [$clog2(COLS*ROWS)-1:0]     addr_o,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] scroll_o,
    output logic [1:0]                       ctrl_o,
    output logic                             buf_we_o
);
    import text_overlay_pkg::*;

    localparam int AW = $clog2(COLS*ROWS);
    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [7:0] ROW_MASK = 8'(ROWS - 1);

    logic [AW-1:0] addr_q, addr_d;
    logic [RW-1:0] scroll_q, scroll_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [8:0]    off_full_s;
    logic          hit_s;
    logic          we_s;
    logic [15:0]   addr_ext_s;
    logic [7:0]    row_s;

    // Port decode and next-state for the address, scroll and control registers.
    always_comb begin
        addr_d     = addr_q;
        scroll_d   = scroll_q;
        ctrl_d     = ctrl_q;
        we_s       = 1'b0;
        // Ports below BASE wrap to large values, so one compare covers both ends.
        off_full_s = {1'b0, port_id_i} - 9'(BASE);
        hit_s      = write_strobe_i && (off_full_s < REG_COUNT);
        addr_ext_s = 16'(addr_q);
        row_s      = out_port_i & ROW_MASK;
        if (hit_s) begin
            case (off_full_s[2:0])
                REG_DATA: begin
                    we_s   = 1'b1;
                    addr_d = addr_q + AW'(1);
                end
                REG_ADDRL:  addr_d   = AW'({addr_ext_s[15:8], out_port_i});
                REG_ADDRH:  addr_d   = AW'({out_port_i, addr_ext_s[7:0]});
                REG_ROW:    addr_d   = AW'(16'(row_s) << CW);
                REG_SCROLL: scroll_d = RW'(row_s);
                REG_CTRL:   ctrl_d   = out_port_i[1:0];
                default:    we_s     = 1'b0;
            endcase
        end else begin
            we_s = 1'b0;
        end
    end

    // Register update; reset wins over any host write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            scroll_q <= '0;
            ctrl_q   <= CTRL_RESET;
        end else begin
            addr_q   <= addr_d;
            scroll_q <= scroll_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign addr_o   = addr_q;
    assign scroll_o = scroll_q;
    assign ctrl_o   = ctrl_q;
    // A data write during reset must not reach the buffer.
    assign buf_we_o = we_s & ~rst;

endmodule

// File: rtl/text_overlay.sv
// Character-cell text overlay: a COLS x ROWS buffer of 8-bit codes rendered
// through an 8x16 glyph ROM into a window at cell (X0, Y0). area/out lag
// hdata/vdata by two cycles (buffer read, then glyph lookup).
// Optional feature: define TEXT_OVERLAY_CURSOR_EN for a blinking cursor
// on the cell at the current write address.
module text_overlay #(
    parameter int BASE = 0,
    parameter int COLS = 16,
    parameter int ROWS = 64,
    parameter int X0   = 112,
    parameter int Y0   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  port_id,
    input  logic [7:0]  out_port,
    input  logic        write_strobe,
    input  logic [11:0] hdata,
    input  logic [11:0] vdata,
    output logic        area,
    output logic        out
);
    import text_overlay_pkg::*;

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [12:0] H_LO   = 13'(X0 * 8);
    localparam logic [12:0] V_LO   = 13'(Y0 * 16);
    localparam logic [12:0] H_SPAN = 13'(COLS * 8);
    localparam logic [12:0] V_SPAN = 13'(ROWS * 16);

    // Glyphs, line 0 in the top byte; pixel 0 of a line is bit 7.
    localparam logic [127:0] GLYPH_A     = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_X     = 128'h0000_C6C6_6C7C_3838_7C6C_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_BLOCK = {128{1'b1}};

    // Glyph ROM; codes without an entry render blank.
    function automatic logic [7:0] glyph_line(input logic [7:0] code, input logic [3:0] line);
        logic [127:0] g;
        logic [6:0]   idx;
        case (code)
            8'h41:   g = GLYPH_A;
            8'h58:   g = GLYPH_X;
            8'hDB:   g = GLYPH_BLOCK;
            default: g = 128'd0;
        endcase
        idx = {4'd15 - line, 3'b000};
        return g[idx +: 8];
    endfunction

    logic [AW-1:0] addr_s;
    logic [RW-1:0] scroll_s;
    logic [1:0]    ctrl_s;
    logic          buf_we_s;

    text_overlay_regs #(
        .BASE (BASE),
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_regs (
        .clk            (clk),
        .rst            (rst),
        .port_id_i      (port_id),
        .out_port_i     (out_port),
        .write_strobe_i (write_strobe),
        .addr_o         (addr_s),
        .scroll_o       (scroll_s),
        .ctrl_o         (ctrl_s),
        .buf_we_o       (buf_we_s)
    );

    // Stage 0: window test and buffer address for the current pixel.
    logic [12:0]   h_off_s, v_off_s;
    logic          h_in_s, v_in_s;
    logic [CW-1:0] col_s;
    logic [RW-1:0] r_s, brow_s;
    logic [AW-1:0] rd_addr_s;

    // Offsets wrap below the window edge, so each axis needs a single compare.
    always_comb begin
        h_off_s   = {1'b0, hdata} - H_LO;
        v_off_s   = {1'b0, vdata} - V_LO;
        h_in_s    = (h_off_s < H_SPAN);
        v_in_s    = (v_off_s < V_SPAN);
        col_s     = h_off_s[CW+2:3];
        r_s       = v_off_s[RW+3:4];
        brow_s    = (r_s + scroll_s) & RW'(ROWS - 1);
        rd_addr_s = AW'((16'(brow_s) << CW) | 16'(col_s));
    end

    // Stage 1: character buffer, write-first so a colliding read sees new data.
    logic [7:0] buf_mem [0:DEPTH-1];
    logic [7:0] code_q;

    // Buffer write port and registered read with same-cell bypass.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem[addr_s] <= out_port;
        end
        if (buf_we_s && (addr_s == rd_addr_s)) begin
            code_q <= out_port;
        end else begin
            code_q <= buf_mem[rd_addr_s];
        end
    end

    logic       valid1_q;
    logic       area1_q;
    logic [2:0] hsel1_q;
    logic [3:0] vsel1_q;

    // Stage 1 sideband: window flag and pixel/line selects travel with the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            area1_q  <= 1'b0;
            hsel1_q  <= 3'd0;
            vsel1_q  <= 4'd0;
        end else begin
            valid1_q <= 1'b1;
            area1_q  <= h_in_s & v_in_s;
            hsel1_q  <= h_off_s[2:0];
            vsel1_q  <= v_off_s[3:0];
        end
    end

`ifdef TEXT_OVERLAY_CURSOR_EN
    logic [4:0] frame_q;
    logic       cursor1_q;

    // Frame counter: one tick per frame at pixel (0,0); bit 4 is the blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= 5'd0;
        end else if ((hdata == 12'd0) && (vdata == 12'd0)) begin
            frame_q <= frame_q + 5'd1;
        end else begin
            frame_q <= frame_q;
        end
    end

    // Marks the pixel as belonging to the cell at the write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor1_q <= 1'b0;
        end else begin
            cursor1_q <= (rd_addr_s == addr_s);
        end
    end
`endif

    // Stage 2: glyph lookup, cursor overlay, invert and enable.
    logic [7:0] glyph_row_s;
    logic       pix_s;
    logic       area_d, out_d;
    logic       area_q, out_q;

    // Pick the glyph bit for this pixel and form the final output values.
    always_comb begin
        glyph_row_s = glyph_line(code_q, vsel1_q);
        pix_s       = glyph_row_s[3'd7 - hsel1_q];
`ifdef TEXT_OVERLAY_CURSOR_EN
        if (frame_q[4] && cursor1_q && (vsel1_q[3:1] == 3'b111)) begin
            pix_s = 1'b1;
        end else begin
            pix_s = glyph_row_s[3'd7 - hsel1_q];
        end
`endif
        area_d = area1_q & valid1_q;
        out_d  = area_d & ctrl_s[CTRL_EN_BIT] & (pix_s ^ ctrl_s[CTRL_INV_BIT]);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            area_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            area_q <= area_d;
            out_q  <= out_d;
        end
    end

    assign area = area_q;
    assign out  = out_q;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay with default geometry (16x64 cells,
// window at x 896..1023, y 0..1023). Expected pixels are hand-derived
// from the 'A' (0x41), 'X' (0x58) and full-block (0xDB) glyphs.
module tb_text_overlay;
    import text_overlay_pkg::*;

    localparam int BASE = 0;
    localparam logic [7:0] P_DATA   = 8'(BASE + int'(REG_DATA));
    localparam logic [7:0] P_ADDRL  = 8'(BASE + int'(REG_ADDRL));
    localparam logic [7:0] P_ADDRH  = 8'(BASE + int'(REG_ADDRH));
    localparam logic [7:0] P_ROW    = 8'(BASE + int'(REG_ROW));
    localparam logic [7:0] P_SCROLL = 8'(BASE + int'(REG_SCROLL));
    localparam logic [7:0] P_CTRL   = 8'(BASE + int'(REG_CTRL));

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic [11:0] hdata;
    logic [11:0] vdata;
    logic        area;
    logic        out;

    int n_vec = 0;
    int n_bad = 0;

    text_overlay #(
        .BASE (BASE),
        .COLS (16),
        .ROWS (64),
        .X0   (112),
        .Y0   (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .hdata        (hdata),
        .vdata        (vdata),
        .area         (area),
        .out          (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [7:0]  scroll;
        logic [11:0] h;
        logic [11:0] v;
        logic        exp_area;
        logic        exp_out;
    } vec_t;

    vec_t vecs [26];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [7:0] p, input logic [7:0] d);
        port_id      = p;
        out_port     = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic show(input logic [11:0] h, input logic [11:0] v);
        hdata = h;
        vdata = v;
        step();
        step();
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            hdata = 12'd0;
            vdata = 12'd0;
            step();
            hdata = 12'd904;
            vdata = 12'd14;
            step();
        end
    endtask

    logic [11:0] hs [8];
    logic        ea [8];
    logic        eo [8];

    initial begin
        // ctrl, scroll, h, v, area, out
        vecs[0]  = '{2'b01, 8'd0, 12'd899,  12'd2,    1'b1, 1'b1}; // A line2 px3
        vecs[1]  = '{2'b01, 8'd0, 12'd896,  12'd2,    1'b1, 1'b0}; // A line2 px0, left edge
        vecs[2]  = '{2'b01, 8'd0, 12'd904,  12'd7,    1'b1, 1'b1}; // cell1 A line7 px0
        vecs[3]  = '{2'b01, 8'd0, 12'd911,  12'd7,    1'b1, 1'b0}; // cell1 A line7 px7
        vecs[4]  = '{2'b01, 8'd0, 12'd912,  12'd5,    1'b1, 1'b1}; // cell2 A line5 px0
        vecs[5]  = '{2'b01, 8'd0, 12'd914,  12'd5,    1'b1, 1'b0}; // cell2 A line5 px2
        vecs[6]  = '{2'b01, 8'd0, 12'd920,  12'd2,    1'b1, 1'b1}; // cell3 X line2 px0
        vecs[7]  = '{2'b01, 8'd0, 12'd923,  12'd6,    1'b1, 1'b1}; // cell3 X line6 px3
        vecs[8]  = '{2'b01, 8'd0, 12'd920,  12'd6,    1'b1, 1'b0}; // cell3 X line6 px0
        vecs[9]  = '{2'b01, 8'd0, 12'd931,  12'd7,    1'b1, 1'b0}; // cell4 blank
        vecs[10] = '{2'b01, 8'd0, 12'd912,  12'd18,   1'b1, 1'b1}; // row1 cell2 X
        vecs[11] = '{2'b01, 8'd0, 12'd895,  12'd2,    1'b0, 1'b0}; // one left of window
        vecs[12] = '{2'b01, 8'd0, 12'd1024, 12'd2,    1'b0, 1'b0}; // one right of window
        vecs[13] = '{2'b01, 8'd0, 12'd1023, 12'd7,    1'b1, 1'b0}; // last column, blank
        vecs[14] = '{2'b01, 8'd0, 12'd900,  12'd1024, 1'b0, 1'b0}; // below window
        vecs[15] = '{2'b01, 8'd1, 12'd896,  12'd2,    1'b1, 1'b1}; // scroll1: X line2 px0
        vecs[16] = '{2'b01, 8'd1, 12'd899,  12'd2,    1'b1, 1'b0}; // scroll1: X line2 px3
        vecs[17] = '{2'b01, 8'd1, 12'd937,  12'd3,    1'b1, 1'b1}; // scroll1: cell5 X px1
        vecs[18] = '{2'b01, 8'd0, 12'd937,  12'd3,    1'b1, 1'b0}; // scroll0: cell5 blank
        vecs[19] = '{2'b01, 8'd1, 12'd899,  12'd1010, 1'b1, 1'b1}; // row63+1 wraps to row0 A
        vecs[20] = '{2'b11, 8'd0, 12'd896,  12'd2,    1'b1, 1'b1}; // invert
        vecs[21] = '{2'b11, 8'd0, 12'd899,  12'd2,    1'b1, 1'b0}; // invert
        vecs[22] = '{2'b11, 8'd0, 12'd895,  12'd2,    1'b0, 1'b0}; // invert, outside
        vecs[23] = '{2'b00, 8'd0, 12'd899,  12'd2,    1'b1, 1'b0}; // disabled
        vecs[24] = '{2'b00, 8'd0, 12'd895,  12'd2,    1'b0, 1'b0}; // disabled, outside
        vecs[25] = '{2'b01, 8'd0, 12'd896,  12'd7,    1'b1, 1'b1}; // back to defaults

        rst          = 1'b1;
        port_id      = 8'd0;
        out_port     = 8'd0;
        write_strobe = 1'b0;
        hdata        = 12'd896;
        vdata        = 12'd2;
        step();
        step();
        step();
        check("reset area", area, 1'b0);
        check("reset out", out, 1'b0);
        rst = 1'b0;

        // Row 0: A A A X then blanks; row 1: all X.
        host_wr(P_DATA, 8'h41);
        host_wr(P_DATA, 8'h41);
        host_wr(P_DATA, 8'h41);
        host_wr(P_DATA, 8'h58);
        for (int i = 0; i < 12; i++) host_wr(P_DATA, 8'h00);
        for (int i = 0; i < 16; i++) host_wr(P_DATA, 8'h58);

        for (int i = 0; i < 26; i++) begin
            host_wr(P_CTRL, {6'b0, vecs[i].ctrl});
            host_wr(P_SCROLL, vecs[i].scroll);
            show(vecs[i].h, vecs[i].v);
            check($sformatf("vec%0d area", i), area, vecs[i].exp_area);
            check($sformatf("vec%0d out", i), out, vecs[i].exp_out);
        end

        // Streaming across the left edge: outputs must lag by exactly two cycles.
        for (int k = 0; k < 8; k++) begin
            hs[k] = 12'(893 + k);
            ea[k] = (k >= 3);
            eo[k] = (k == 6);
        end
        vdata = 12'd2;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) hdata = hs[k];
            step();
            if (k >= 1) begin
                check($sformatf("lat h%0d area", hs[k-1]), area, ea[k-1]);
                check($sformatf("lat h%0d out", hs[k-1]), out, eo[k-1]);
            end
        end

        // Write-first: write X to cell 6 in the same cycle it is displayed.
        host_wr(P_ADDRL, 8'd6);
        host_wr(P_ADDRH, 8'd0);
        show(12'd895, 12'd2);
        hdata        = 12'd944;
        port_id      = P_DATA;
        out_port     = 8'h58;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        hdata        = 12'd895;
        step();
        check("collision area", area, 1'b1);
        check("collision out", out, 1'b1);

        // Mid-line reset with a discarded write; registers return to defaults.
        host_wr(P_CTRL, 8'h03);
        host_wr(P_SCROLL, 8'h01);
        show(12'd900, 12'd2);
        check("pre-rst out", out, 1'b1);
        rst          = 1'b1;
        port_id      = P_DATA;
        out_port     = 8'hDB;
        write_strobe = 1'b1;
        step();
        rst          = 1'b0;
        write_strobe = 1'b0;
        check("rst area", area, 1'b0);
        check("rst out", out, 1'b0);
        step();
        check("rst+1 area", area, 1'b0);
        step();
        check("rst+2 area", area, 1'b1);
        check("rst+2 out", out, 1'b0);
        show(12'd899, 12'd2);
        check("rst ctrl/scroll default", out, 1'b1);
        show(12'd952, 12'd2);
        check("rst write dropped", out, 1'b0);
        host_wr(P_DATA, 8'h58);
        show(12'd896, 12'd2);
        check("rst addr zero", out, 1'b1);

        // Address setters.
        host_wr(P_ROW, 8'd5);
        host_wr(P_DATA, 8'hDB);
        show(12'd896, 12'd89);
        check("row5 start", out, 1'b1);
        host_wr(P_ROW, 8'h46);
        host_wr(P_DATA, 8'hDB);
        show(12'd898, 12'd100);
        check("row mod ROWS", out, 1'b1);
        host_wr(P_ADDRL, 8'h10);
        host_wr(P_ADDRH, 8'hFD);
        host_wr(P_DATA, 8'hDB);
        show(12'd896, 12'd275);
        check("addrh drops high bits", out, 1'b1);
        host_wr(P_ADDRL, 8'hFF);
        host_wr(P_ADDRH, 8'h07);
        host_wr(P_DATA, 8'hDB);
        host_wr(P_DATA, 8'h41);
        show(12'd1023, 12'd1023);
        check("cell 1023", out, 1'b1);
        show(12'd896, 12'd2);
        check("wrap to 0 px0", out, 1'b0);
        show(12'd899, 12'd2);
        check("wrap to 0 px3", out, 1'b1);

        // Writes outside the block, or without the strobe, have no effect.
        host_wr(8'd8, 8'h00);
        host_wr(8'd13, 8'h00);
        port_id  = P_CTRL;
        out_port = 8'h00;
        step();
        show(12'd907, 12'd2);
        check("ignored ports", out, 1'b1);

`ifdef TEXT_OVERLAY_CURSOR_EN
        // Cursor sits on cell 1 (A, whose lines 14-15 are blank).
        frames(16);
        show(12'd904, 12'd14);
        check("cursor on line14", out, 1'b1);
        show(12'd911, 12'd15);
        check("cursor on line15", out, 1'b1);
        show(12'd904, 12'd13);
        check("cursor line13", out, 1'b0);
        show(12'd896, 12'd14);
        check("non-cursor cell", out, 1'b0);
        frames(16);
        show(12'd904, 12'd14);
        check("cursor off", out, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
